psum_collector: RTL and testbench
=================================

# psum_collector

Assembles per-sub-macro column partial sums, delivered in narrow beats, into full-width frames and presents them to the cross-macro merging stage. Sits directly upstream of the merging/adder-tree stage: it drives `psum_buff_out` / `psum_data_ready` and consumes `psum_ack`. Each sub-macro has an independent ping-pong frame buffer, so a macro can stream its next frame while the previous one waits for merging.

## Interface
- `NUM_SUB_MACROS`, 4, number of sub-macros (independent lanes).
- `NUM_COLS`, 32, columns per sub-macro frame.
- `ODATA_WIDTH`, 20, width of one column psum (signed, passed through unmodified).
- `COLS_PER_BEAT`, 8, columns per input beat; `NUM_COLS % COLS_PER_BEAT == 0`. `BEATS = NUM_COLS/COLS_PER_BEAT`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort of all lanes.
- `mac_out_data`  in  `NUM_SUB_MACROS*COLS_PER_BEAT*ODATA_WIDTH`  beat from lane m at `[m*COLS_PER_BEAT*ODATA_WIDTH +: COLS_PER_BEAT*ODATA_WIDTH]`, column j of beat at `+j*ODATA_WIDTH`.
- `mac_out_valid`  in  `NUM_SUB_MACROS`  beat valid per lane.
- `mac_out_ready`  out  `NUM_SUB_MACROS`  beat accept per lane.
- `psum_buff_out`  out  `NUM_SUB_MACROS*NUM_COLS*ODATA_WIDTH`  frame; lane m, column c at word `m*NUM_COLS + c`.
- `psum_data_ready`  out  `NUM_SUB_MACROS`  registered frame-available per lane.
- `psum_ack`  in  `NUM_SUB_MACROS`  frame consumed per lane.

## Operation
- Per lane state: `wr_bank`, `rd_bank` (1 bit each), `beat_cnt` (0..BEATS-1), `full[1:0]`, `ready_q`; two banks of `NUM_COLS*ODATA_WIDTH`.
- `mac_out_ready[m] = !full[wr_bank] && !clear`. Beat accepted when valid && ready: writes columns `beat_cnt*COLS_PER_BEAT +: COLS_PER_BEAT` of bank `wr_bank`; `beat_cnt++`.
- Last beat (`beat_cnt == BEATS-1`): `full[wr_bank] <= 1`, `wr_bank` toggles, `beat_cnt <= 0`.
- Ack accepted only when `psum_ack[m] && psum_data_ready[m]` in the same cycle: `full[rd_bank] <= 0`, `rd_bank` toggles, `ready_q <= 0`. Ack while `psum_data_ready[m] == 0` is ignored.
- Otherwise `ready_q <= full[rd_bank]`. `psum_data_ready = ready_q`; `psum_buff_out` lane m = bank `rd_bank`, combinational from storage.
- Simultaneous last-beat write and ack on the same lane: both take effect; the bank freed by ack is the non-write bank, so no conflict.
- `clear`: highest priority below reset; all lanes `beat_cnt`, `full`, `wr_bank`, `rd_bank`, `ready_q` to 0; storage retained; beats presented in the clear cycle are not accepted.
- Lanes are fully independent; no cross-lane alignment is done here.

## Timing
- Reset values: `psum_data_ready = 0`, `psum_buff_out = 0` (storage reset to 0), `mac_out_ready = all 1`.
- Last beat accepted at edge e → `psum_data_ready` high after edge e+1.
- Ack accepted at edge a → `psum_data_ready` low for at least the cycle after a; next frame visible after edge a+1 at the earliest. This tolerates a one-cycle-late registered ack held for 2 cycles without releasing a second bank.
- `psum_buff_out` lane m is stable from `psum_data_ready` rise through the cycle ack is accepted and unchanged until edge a.
- Sustained throughput: one frame per BEATS cycles per lane while acks keep up; with both banks full, `mac_out_ready[m]` is low until one ack.
- Asynchronous reset mid-frame discards all partial and full frames.

## Structure
- Shared package `psum_pkg`: function for counter width (`clog2`), bank-index constants `BANK0/BANK1`.
- One sub-module `psum_pingpong_lane` (one lane: counters, two banks, ready/ack logic), instantiated `NUM_SUB_MACROS` times by generate. The top level only slices buses.

## Test plan
- Defaults; each lane sends one frame, column value `m*100+c` → `psum_data_ready = 4'b1111` one cycle after the last beat; word (m=2,c=5) = 205; 1-cycle ack → ready low one cycle.
- Lane 0 sends 3 frames, no ack → `mac_out_ready[0] = 0` after 8 beats; frame 3 stalls; ack → ready low 1 cycle, then high with frame 2 data; frame 3 resumes.
- Ack held high 2 consecutive cycles → exactly one bank released; frame 2 presented intact 2 cycles after first ack edge.
- Lane 3 delayed 5 cycles → ready bits rise independently; ack on `4'b1111` while lane 3 not ready leaves lane 3 frame pending.
- `clear` after 2 beats of lane 1 → ready stays 0; next 4 beats form a complete frame with new values.
- `rst_n` low mid-frame with a full bank → all outputs reset values; after release a fresh frame is handled correctly.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum collector: bank indices and counter sizing.
// Pure package, no logic.
package psum_pkg;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  // Bits needed to count 0..value-1; never returns less than 1 so a one-beat frame still gets a counter.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/psum_pingpong_lane.sv
// One sub-macro lane: assembles beats into frames in two ping-pong banks, ready one cycle after the last beat.
// Beats stall (beat_ready low) while the write bank is still waiting for an ack; acks count only while frame_ready is high.
module psum_pingpong_lane
  import psum_pkg::*;
#(
  parameter int NUM_COLS      = 32,
  parameter int ODATA_WIDTH   = 20,
  parameter int COLS_PER_BEAT = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic [COLS_PER_BEAT*ODATA_WIDTH-1:0] beat_data,
  input  logic                              beat_valid,
  output logic                              beat_ready,
  output logic [NUM_COLS*ODATA_WIDTH-1:0]   frame,
  output logic                              frame_ready,
  input  logic                              ack
);

  localparam int BEATS   = NUM_COLS / COLS_PER_BEAT;
  localparam int BEAT_W  = COLS_PER_BEAT * ODATA_WIDTH;
  localparam int FRAME_W = NUM_COLS * ODATA_WIDTH;
  localparam int CNT_W   = clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic               wr_bank;
  logic               rd_bank;
  logic [CNT_W-1:0]   beat_cnt;
  logic [1:0]         full;
  logic [1:0]         full_nxt;
  logic               ready_q;
  logic [FRAME_W-1:0] bank_mem [2];
  logic               accept;
  logic               last_beat;
  logic               ack_take;

  assign beat_ready  = !full[wr_bank] && !clear;
  assign accept      = beat_valid && beat_ready;
  assign last_beat   = accept && (beat_cnt == LAST_BEAT);
  assign ack_take    = ack && ready_q;
  assign frame_ready = ready_q;
  assign frame       = (rd_bank == BANK1) ? bank_mem[1] : bank_mem[0];

  // A completing write and an ack never hit the same bank: the write bank is only writable while empty.
  always_comb begin
    full_nxt = full;
    if (last_beat) full_nxt[wr_bank] = 1'b1;
    if (ack_take)  full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank     <= BANK0;
      rd_bank     <= BANK0;
      beat_cnt    <= '0;
      full        <= '0;
      ready_q     <= 1'b0;
      bank_mem[0] <= '0;
      bank_mem[1] <= '0;
    end else if (clear) begin
      wr_bank  <= BANK0;
      rd_bank  <= BANK0;
      beat_cnt <= '0;
      full     <= '0;
      ready_q  <= 1'b0;
    end else begin
      for (int b = 0; b < BEATS; b++) begin
        if (accept && (beat_cnt == CNT_W'(b))) bank_mem[wr_bank][b*BEAT_W +: BEAT_W] <= beat_data;
      end
      if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        if (last_beat) wr_bank <= ~wr_bank;
      end
      full <= full_nxt;
      // Dropping ready for a cycle after an ack keeps a stretched ack from releasing the next bank too.
      if (ack_take) begin
        rd_bank <= ~rd_bank;
        ready_q <= 1'b0;
      end else begin
        ready_q <= full[rd_bank];
      end
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Per-sub-macro frame collectors feeding the merge stage; each lane is independent, ready one cycle after its last beat.
// A lane stalls its beat input only while both of its banks hold unacknowledged frames.
module psum_collector
  import psum_pkg::*;
#(
  parameter int NUM_SUB_MACROS = 4,
  parameter int NUM_COLS       = 32,
  parameter int ODATA_WIDTH    = 20,
  parameter int COLS_PER_BEAT  = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            clear,
  input  logic [NUM_SUB_MACROS*COLS_PER_BEAT*ODATA_WIDTH-1:0] mac_out_data,
  input  logic [NUM_SUB_MACROS-1:0]                       mac_out_valid,
  output logic [NUM_SUB_MACROS-1:0]                       mac_out_ready,
  output logic [NUM_SUB_MACROS*NUM_COLS*ODATA_WIDTH-1:0]  psum_buff_out,
  output logic [NUM_SUB_MACROS-1:0]                       psum_data_ready,
  input  logic [NUM_SUB_MACROS-1:0]                       psum_ack
);

  localparam int BEAT_W  = COLS_PER_BEAT * ODATA_WIDTH;
  localparam int FRAME_W = NUM_COLS * ODATA_WIDTH;

  for (genvar m = 0; m < NUM_SUB_MACROS; m++) begin : g_lane
    psum_pingpong_lane #(
      .NUM_COLS      (NUM_COLS),
      .ODATA_WIDTH   (ODATA_WIDTH),
      .COLS_PER_BEAT (COLS_PER_BEAT)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .beat_data   (mac_out_data[m*BEAT_W +: BEAT_W]),
      .beat_valid  (mac_out_valid[m]),
      .beat_ready  (mac_out_ready[m]),
      .frame       (psum_buff_out[m*FRAME_W +: FRAME_W]),
      .frame_ready (psum_data_ready[m]),
      .ack         (psum_ack[m])
    );
  end

endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector: scenario tasks plus randomized traffic against a frame-queue reference model.
`timescale 1ns/1ps
module tb_psum_collector;
  localparam int NSM = 4, NC = 32, W = 20, CPB = 8;
  localparam int BEATS = NC / CPB, FW = NC * W, BW = CPB * W;

  logic               clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [NSM*BW-1:0]  mac_out_data = '0;
  logic [NSM-1:0]     mac_out_valid = '0, mac_out_ready, psum_data_ready, psum_ack = '0;
  logic [NSM*FW-1:0]  psum_buff_out;

  int n_cmp = 0, n_err = 0;

  psum_collector #(.NUM_SUB_MACROS(NSM), .NUM_COLS(NC), .ODATA_WIDTH(W), .COLS_PER_BEAT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .mac_out_data(mac_out_data), .mac_out_valid(mac_out_valid), .mac_out_ready(mac_out_ready),
    .psum_buff_out(psum_buff_out), .psum_data_ready(psum_data_ready), .psum_ack(psum_ack)
  );

  always #5 clk = ~clk;

  // Reference model: each lane holds at most two finished frames awaiting ack; a frame is
  // announced one cycle after it completes, and an accepted ack hides the next one for a cycle.
  logic [FW-1:0]  mq [NSM][$];
  logic [FW-1:0]  part [NSM];
  int             pcnt [NSM];
  logic [NSM-1:0] rdy_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < NSM; m++) begin mq[m].delete(); pcnt[m] = 0; end
      rdy_exp = '0;
    end else begin
      for (int m = 0; m < NSM; m++) begin
        int sz;
        bit take;
        if (clear) begin
          mq[m].delete(); pcnt[m] = 0; rdy_exp[m] = 1'b0;
        end else begin
          sz = mq[m].size();
          take = psum_ack[m] && rdy_exp[m];
          if (take) void'(mq[m].pop_front());
          if (mac_out_valid[m] && sz < 2) begin
            part[m][pcnt[m]*BW +: BW] = mac_out_data[m*BW +: BW];
            pcnt[m]++;
            if (pcnt[m] == BEATS) begin mq[m].push_back(part[m]); pcnt[m] = 0; end
          end
          rdy_exp[m] = !take && (sz > 0);
        end
      end
    end
  end

  // Beat source: per-lane queue of beats, presented 1ns after each rising edge.
  logic [BW-1:0]  src [NSM][$];
  logic [NSM-1:0] en, acc;
  bit             gap_en;

  task automatic driver();
    forever begin
      @(negedge clk);
      acc = mac_out_valid & mac_out_ready;
      @(posedge clk);
      #1;
      for (int m = 0; m < NSM; m++) begin
        if (acc[m] && src[m].size() > 0) void'(src[m].pop_front());
        if (rst_n && en[m] && src[m].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
          mac_out_valid[m] = 1'b1;
          mac_out_data[m*BW +: BW] = src[m][0];
        end else begin
          mac_out_valid[m] = 1'b0;
        end
      end
    end
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int c = 0; c < NC; c++) f[c*W +: W] = W'($urandom);
    return f;
  endfunction

  task automatic push_frame(input int m, input logic [FW-1:0] f, input int nb);
    for (int b = 0; b < nb; b++) src[m].push_back(f[b*BW +: BW]);
  endtask

  task automatic wait_src_empty(input int m, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin @(negedge clk); ok = (src[m].size() == 0); end
  endtask

  task automatic wait_lane_ready(input int m, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin @(negedge clk); ok = psum_data_ready[m]; end
  endtask

  task automatic drain(input int m);
    for (int i = 0; i < 80 && (mq[m].size() > 0 || src[m].size() > 0); i++) begin
      @(negedge clk);
      if (psum_data_ready[m]) begin
        @(posedge clk); #2 psum_ack[m] = 1'b1;
        @(posedge clk); #2 psum_ack[m] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (psum_data_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", psum_data_ready); end
    n_cmp++; if (mac_out_ready !== 4'b1111) begin n_err++; $display("FAIL reset_mac_ready: got %b want 1111", mac_out_ready); end
    n_cmp++; if (psum_buff_out !== '0) begin n_err++; $display("FAIL reset_buff: got %0d set bits want 0", $countones(psum_buff_out)); end
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (psum_data_ready !== 4'b0000 || mac_out_ready !== 4'b1111) begin
      n_err++; $display("FAIL reset_release: got ready %b mac_ready %b want 0000 1111", psum_data_ready, mac_out_ready);
    end
  endtask

  task automatic test_one_frame();
    logic [FW-1:0] f;
    bit seen;
    for (int m = 0; m < NSM; m++) begin
      for (int c = 0; c < NC; c++) f[c*W +: W] = W'(m*100 + c);
      push_frame(m, f, BEATS);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      n_cmp++; if (psum_data_ready !== rdy_exp) begin
        n_err++; $display("FAIL one_frame_timing cycle %0d: got %b want %b", i, psum_data_ready, rdy_exp);
      end
      seen = (psum_data_ready != 0);
    end
    n_cmp++; if (psum_data_ready !== 4'b1111) begin n_err++; $display("FAIL one_frame_ready: got %b want 1111", psum_data_ready); end
    n_cmp++; if (psum_buff_out[(2*NC+5)*W +: W] !== W'(205)) begin
      n_err++; $display("FAIL one_frame_word_2_5: got %0d want 205", psum_buff_out[(2*NC+5)*W +: W]);
    end
    n_cmp++; if (psum_buff_out[(3*NC+31)*W +: W] !== W'(331)) begin
      n_err++; $display("FAIL one_frame_word_3_31: got %0d want 331", psum_buff_out[(3*NC+31)*W +: W]);
    end
    @(posedge clk); #2 psum_ack = '1;
    @(posedge clk); #2 psum_ack = '0;
    @(negedge clk);
    n_cmp++; if (psum_data_ready !== 4'b0000) begin n_err++; $display("FAIL one_frame_ack_drop: got %b want 0000", psum_data_ready); end
    @(negedge clk);
    n_cmp++; if (psum_data_ready !== 4'b0000 || mac_out_ready !== 4'b1111) begin
      n_err++; $display("FAIL one_frame_idle: got ready %b mac_ready %b want 0000 1111", psum_data_ready, mac_out_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] f1, f2, f3;
    bit ok;
    f1 = rand_frame(); f2 = rand_frame(); f3 = rand_frame();
    push_frame(0, f1, BEATS); push_frame(0, f2, BEATS); push_frame(0, f3, BEATS);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); ok = (src[0].size() <= BEATS); end
    n_cmp++; if (!ok || mac_out_ready[0] !== 1'b0) begin
      n_err++; $display("FAIL bp_stall: got reached=%0d mac_ready=%b want 1 0", ok, mac_out_ready[0]);
    end
    repeat (6) @(negedge clk);
    n_cmp++; if (src[0].size() != BEATS) begin n_err++; $display("FAIL bp_frame3_held: got %0d beats left want %0d", src[0].size(), BEATS); end
    n_cmp++; if (psum_data_ready[0] !== 1'b1 || psum_buff_out[0 +: FW] !== f1) begin
      n_err++; $display("FAIL bp_frame1: got ready %b data %h want 1 %h", psum_data_ready[0], psum_buff_out[0 +: FW], f1);
    end
    @(posedge clk); #2 psum_ack[0] = 1'b1;
    @(posedge clk); #2 psum_ack[0] = 1'b0;
    @(negedge clk);
    n_cmp++; if (psum_data_ready[0] !== 1'b0 || mac_out_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL bp_after_ack: got ready %b mac_ready %b want 0 1", psum_data_ready[0], mac_out_ready[0]);
    end
    @(negedge clk);
    n_cmp++; if (psum_data_ready[0] !== 1'b1 || psum_buff_out[0 +: FW] !== f2) begin
      n_err++; $display("FAIL bp_frame2: got ready %b data %h want 1 %h", psum_data_ready[0], psum_buff_out[0 +: FW], f2);
    end
    wait_src_empty(0, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_frame3_resume: got %0d beats left want 0", src[0].size()); end
    @(posedge clk); #2 psum_ack[0] = 1'b1;
    @(posedge clk); #2 psum_ack[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (psum_data_ready[0] !== 1'b1 || psum_buff_out[0 +: FW] !== f3) begin
      n_err++; $display("FAIL bp_frame3: got ready %b data %h want 1 %h", psum_data_ready[0], psum_buff_out[0 +: FW], f3);
    end
    drain(0);
  endtask

  task automatic test_ack_hold();
    logic [FW-1:0] f1, f2;
    bit ok;
    f1 = rand_frame(); f2 = rand_frame();
    push_frame(1, f1, BEATS); push_frame(1, f2, BEATS);
    wait_src_empty(1, ok);
    n_cmp++; if (!ok || psum_data_ready[1] !== 1'b1 || mac_out_ready[1] !== 1'b0 || psum_buff_out[FW +: FW] !== f1) begin
      n_err++; $display("FAIL hold_pre: got done=%0d ready %b mac_ready %b want 1 1 0, frame1 match %0d", ok, psum_data_ready[1], mac_out_ready[1], psum_buff_out[FW +: FW] === f1);
    end
    @(posedge clk); #2 psum_ack[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (psum_data_ready[1] !== 1'b0) begin n_err++; $display("FAIL hold_drop: got %b want 0", psum_data_ready[1]); end
    @(posedge clk); #2 psum_ack[1] = 1'b0;
    @(negedge clk);
    n_cmp++; if (psum_data_ready[1] !== 1'b1 || psum_buff_out[FW +: FW] !== f2 || mac_out_ready[1] !== 1'b1) begin
      n_err++; $display("FAIL hold_frame2: got ready %b mac_ready %b data %h want 1 1 %h", psum_data_ready[1], mac_out_ready[1], psum_buff_out[FW +: FW], f2);
    end
    @(negedge clk);
    n_cmp++; if (psum_data_ready[1] !== 1'b1 || psum_buff_out[FW +: FW] !== f2) begin
      n_err++; $display("FAIL hold_frame2_stable: got ready %b data %h want 1 %h", psum_data_ready[1], psum_buff_out[FW +: FW], f2);
    end
    drain(1);
  endtask

  task automatic test_independent();
    logic [FW-1:0] fr [NSM];
    bit ok;
    for (int m = 0; m < NSM; m++) begin fr[m] = rand_frame(); push_frame(m, fr[m], BEATS); end
    en = 4'b0111;
    repeat (5) @(posedge clk);
    #2 en[3] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin @(negedge clk); ok = (psum_data_ready != 0); end
    n_cmp++; if (psum_data_ready !== 4'b0111) begin n_err++; $display("FAIL indep_first: got %b want 0111", psum_data_ready); end
    @(posedge clk); #2 psum_ack = 4'b1111;
    @(posedge clk); #2 psum_ack = 4'b0000;
    @(negedge clk);
    n_cmp++; if (psum_data_ready !== 4'b0000) begin n_err++; $display("FAIL indep_after_ack: got %b want 0000", psum_data_ready); end
    wait_lane_ready(3, ok);
    n_cmp++; if (!ok || psum_data_ready !== 4'b1000 || psum_buff_out[3*FW +: FW] !== fr[3]) begin
      n_err++; $display("FAIL indep_lane3: got ready %b data %h want 1000 %h", psum_data_ready, psum_buff_out[3*FW +: FW], fr[3]);
    end
    drain(3);
  endtask

  task automatic test_clear();
    logic [FW-1:0] fa, fb;
    bit ok;
    fa = rand_frame(); fb = rand_frame();
    push_frame(1, fa, 2);
    wait_src_empty(1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL clear_partial_sent: got %0d beats left want 0", src[1].size()); end
    @(posedge clk); #2 clear = 1'b1;
    push_frame(1, fb, BEATS);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (mac_out_valid[1] !== 1'b1 || mac_out_ready !== 4'b0000) begin
      n_err++; $display("FAIL clear_blocks_beat: got valid %b mac_ready %b want 1 0000", mac_out_valid[1], mac_out_ready);
    end
    @(posedge clk); #2 clear = 1'b0;
    wait_src_empty(1, ok);
    n_cmp++; if (!ok || psum_data_ready[1] !== 1'b0) begin
      n_err++; $display("FAIL clear_no_early_frame: got done=%0d ready %b want 1 0", ok, psum_data_ready[1]);
    end
    @(negedge clk);
    n_cmp++; if (psum_data_ready[1] !== 1'b1 || psum_buff_out[FW +: FW] !== fb) begin
      n_err++; $display("FAIL clear_new_frame: got ready %b data %h want 1 %h", psum_data_ready[1], psum_buff_out[FW +: FW], fb);
    end
    drain(1);
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] g;
    bit ok, ok2;
    push_frame(0, rand_frame(), BEATS); push_frame(0, rand_frame(), BEATS);
    push_frame(1, rand_frame(), 2);
    wait_src_empty(0, ok); wait_src_empty(1, ok2);
    n_cmp++; if (!ok || !ok2 || psum_data_ready[0] !== 1'b1 || mac_out_ready[0] !== 1'b0) begin
      n_err++; $display("FAIL rst_pre: got done=%0d/%0d ready %b mac_ready %b want 1/1 1 0", ok, ok2, psum_data_ready[0], mac_out_ready[0]);
    end
    @(posedge clk); #2 rst_n = 1'b0;
    for (int m = 0; m < NSM; m++) src[m].delete();
    mac_out_valid = '0;
    #1;
    n_cmp++; if (psum_data_ready !== 4'b0000) begin n_err++; $display("FAIL rst_mid_ready: got %b want 0000", psum_data_ready); end
    n_cmp++; if (mac_out_ready !== 4'b1111) begin n_err++; $display("FAIL rst_mid_mac_ready: got %b want 1111", mac_out_ready); end
    n_cmp++; if (psum_buff_out !== '0) begin n_err++; $display("FAIL rst_mid_buff: got %0d set bits want 0", $countones(psum_buff_out)); end
    @(posedge clk); #2 rst_n = 1'b1;
    g = rand_frame();
    push_frame(1, g, BEATS);
    wait_lane_ready(1, ok);
    n_cmp++; if (!ok || psum_data_ready !== 4'b0010 || psum_buff_out[FW +: FW] !== g) begin
      n_err++; $display("FAIL rst_fresh_frame: got ready %b data %h want 0010 %h", psum_data_ready, psum_buff_out[FW +: FW], g);
    end
    drain(1);
  endtask

  task automatic test_back_to_back();
    logic [NSM-1:0] exp_mr;
    gap_en = 1'b1;
    for (int m = 0; m < NSM; m++) for (int k = 0; k < 3; k++) push_frame(m, rand_frame(), BEATS);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2 psum_ack = NSM'($urandom_range(0, 15));
      @(negedge clk);
      n_cmp++; if (psum_data_ready !== rdy_exp) begin
        n_err++; $display("FAIL rand_ready cycle %0d: got %b want %b", i, psum_data_ready, rdy_exp);
      end
      for (int m = 0; m < NSM; m++) exp_mr[m] = (mq[m].size() < 2);
      n_cmp++; if (mac_out_ready !== exp_mr) begin
        n_err++; $display("FAIL rand_mac_ready cycle %0d: got %b want %b", i, mac_out_ready, exp_mr);
      end
      for (int m = 0; m < NSM; m++) begin
        if (rdy_exp[m]) begin
          n_cmp++; if (psum_buff_out[m*FW +: FW] !== mq[m][0]) begin
            n_err++; $display("FAIL rand_data lane %0d cycle %0d: got %h want %h", m, i, psum_buff_out[m*FW +: FW], mq[m][0]);
          end
        end
      end
    end
    @(posedge clk); #2 psum_ack = '0;
    gap_en = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (psum_data_ready !== 4'b0000 || mac_out_ready !== 4'b1111 || (src[0].size() + src[1].size() + src[2].size() + src[3].size()) != 0) begin
      n_err++; $display("FAIL rand_drained: got ready %b mac_ready %b want 0000 1111 with all beats sent", psum_data_ready, mac_out_ready);
    end
  endtask

  initial begin
    en = '1;
    gap_en = 1'b0;
    fork
      driver();
    join_none
    test_reset();
    test_one_frame();
    test_backpressure();
    test_ack_hold();
    test_independent();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
